// File: rtl/wta_pkg.sv
// Shared types and helpers for the winner-take-all scan controller.
// WTA_UNIQUENESS_EN enables second-minimum tracking and out_unique.
package wta_pkg;

   localparam int COST_W = 16;
   localparam int DISP_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   function automatic logic [COST_W-1:0] sat_add4(
      input logic [COST_W-1:0] a,
      input logic [COST_W-1:0] b,
      input logic [COST_W-1:0] c,
      input logic [COST_W-1:0] d
   );
      logic [COST_W+1:0] s;
      s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
      if (s > {2'b00, {COST_W{1'b1}}})
         return {COST_W{1'b1}};
      return s[COST_W-1:0];
   endfunction

endpackage

// File: rtl/wta_scan_ctrl_if.sv
// Pixel-in / disparity-out handshake bundle for wta_scan_ctrl.
// out_unique exists only when WTA_UNIQUENESS_EN is defined.
interface wta_scan_ctrl_if #(
   parameter int MAX_DISP = 16
);
   import wta_pkg::*;

   logic                       in_valid;
   logic                       in_ready;
   logic [MAX_DISP*COST_W-1:0] path1_cost_flat;
   logic [MAX_DISP*COST_W-1:0] path2_cost_flat;
   logic [MAX_DISP*COST_W-1:0] path3_cost_flat;
   logic [MAX_DISP*COST_W-1:0] path4_cost_flat;
   logic                       out_valid;
   logic                       out_ready;
   logic [DISP_W-1:0]          best_disparity;
   logic [COST_W-1:0]          min_energy;
   logic                       busy;
`ifdef WTA_UNIQUENESS_EN
   logic                       out_unique;
`endif

   modport master (
`ifdef WTA_UNIQUENESS_EN
      input  out_unique,
`endif
      output in_valid,
      output path1_cost_flat,
      output path2_cost_flat,
      output path3_cost_flat,
      output path4_cost_flat,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  best_disparity,
      input  min_energy,
      input  busy
   );

   modport slave (
`ifdef WTA_UNIQUENESS_EN
      output out_unique,
`endif
      input  in_valid,
      input  path1_cost_flat,
      input  path2_cost_flat,
      input  path3_cost_flat,
      input  path4_cost_flat,
      input  out_ready,
      output in_ready,
      output out_valid,
      output best_disparity,
      output min_energy,
      output busy
   );

endinterface

// File: rtl/wta_lane_reduce.sv
// Combinational LANES-wide min reduction; lower lane index wins ties.
// WTA_UNIQUENESS_EN adds second-minimum tracking.
module wta_lane_reduce
   import wta_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic [LANES-1:0][COST_W-1:0] energy,
   input  logic [DISP_W-1:0]            base,
   input  logic [COST_W-1:0]            min_in,
   input  logic [DISP_W-1:0]            best_in,
`ifdef WTA_UNIQUENESS_EN
   input  logic [COST_W-1:0]            second_in,
   output logic [COST_W-1:0]            second_out,
`endif
   output logic [COST_W-1:0]            min_out,
   output logic [DISP_W-1:0]            best_out
);

   always_comb begin
      min_out  = min_in;
      best_out = best_in;
`ifdef WTA_UNIQUENESS_EN
      second_out = second_in;
`endif
      for (int i = 0; i < LANES; i++) begin
         if (energy[i] < min_out) begin
`ifdef WTA_UNIQUENESS_EN
            // the displaced minimum becomes a non-winner candidate
            second_out = min_out;
`endif
            min_out  = energy[i];
            best_out = base + DISP_W'(i);
         end
`ifdef WTA_UNIQUENESS_EN
         else if (energy[i] < second_out) begin
            second_out = energy[i];
         end
`endif
      end
   end

endmodule

// File: rtl/wta_scan_ctrl.sv
// Time-multiplexed WTA scheduler: captures four path-cost vectors and
// scans LANES disparities per cycle. Optional macro: WTA_UNIQUENESS_EN.
module wta_scan_ctrl
   import wta_pkg::*;
#(
   parameter int MAX_DISP    = 16,
   parameter int LANES       = 4,
   parameter int UNIQ_MARGIN = 8
) (
   input logic           clk,
   input logic           rst,
   wta_scan_ctrl_if.slave bus
);

   localparam int NB = MAX_DISP / LANES;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int IW = $clog2(MAX_DISP);

   state_t state;
   state_t state_nx;

   logic [MAX_DISP-1:0][COST_W-1:0] cap1;
   logic [MAX_DISP-1:0][COST_W-1:0] cap2;
   logic [MAX_DISP-1:0][COST_W-1:0] cap3;
   logic [MAX_DISP-1:0][COST_W-1:0] cap4;

   logic [BW-1:0]                beat;
   logic [DISP_W-1:0]            base;
   logic [LANES-1:0][COST_W-1:0] energy;
   logic [COST_W-1:0]            run_min;
   logic [COST_W-1:0]            nx_min;
   logic [DISP_W-1:0]            run_best;
   logic [DISP_W-1:0]            nx_best;
`ifdef WTA_UNIQUENESS_EN
   logic [COST_W-1:0]            run_second;
   logic [COST_W-1:0]            nx_second;
`endif

   logic accept;
   logic last;
   logic hand;

   assign accept = bus.in_valid && (state == IDLE);
   assign last   = (beat == BW'(NB - 1));
   assign hand   = (state == DONE) && bus.out_ready;
   assign base   = DISP_W'(beat) * DISP_W'(LANES);

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.in_valid) state_nx = SCAN;
         SCAN: if (last) state_nx = DONE;
         DONE: if (hand) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // handshake outputs
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.busy      = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cap1 <= bus.path1_cost_flat;
         cap2 <= bus.path2_cost_flat;
         cap3 <= bus.path3_cost_flat;
         cap4 <= bus.path4_cost_flat;
      end
   end

   always_comb begin
      energy = '0;
      for (int i = 0; i < LANES; i++) begin
         energy[i] = sat_add4(cap1[IW'(base) + IW'(i)],
                              cap2[IW'(base) + IW'(i)],
                              cap3[IW'(base) + IW'(i)],
                              cap4[IW'(base) + IW'(i)]);
      end
   end

   wta_lane_reduce #(
      .LANES(LANES)
   ) u_reduce (
      .energy    (energy),
      .base      (base),
      .min_in    (run_min),
      .best_in   (run_best),
`ifdef WTA_UNIQUENESS_EN
      .second_in (run_second),
      .second_out(nx_second),
`endif
      .min_out   (nx_min),
      .best_out  (nx_best)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         beat               <= '0;
         run_min            <= '1;
         run_best           <= '0;
         bus.best_disparity <= '0;
         bus.min_energy     <= '1;
`ifdef WTA_UNIQUENESS_EN
         run_second         <= '1;
         bus.out_unique     <= 1'b0;
`endif
      end else if (accept) begin
         beat     <= '0;
         run_min  <= '1;
         run_best <= '0;
`ifdef WTA_UNIQUENESS_EN
         run_second <= '1;
`endif
      end else if (state == SCAN) begin
         beat     <= last ? '0 : beat + 1'b1;
         run_min  <= nx_min;
         run_best <= nx_best;
`ifdef WTA_UNIQUENESS_EN
         run_second <= nx_second;
`endif
         if (last) begin
            bus.best_disparity <= nx_best;
            bus.min_energy     <= nx_min;
`ifdef WTA_UNIQUENESS_EN
            bus.out_unique <=
               (nx_second - nx_min) >= COST_W'(UNIQ_MARGIN);
`endif
         end
      end
   end

endmodule
